data_mem_if: RTL and testbench
==============================

# data_mem_if

Data-memory access unit between the pipelined MIPS core's MEM stage and the synchronous data RAM. Converts byte/halfword/word load/store requests into word-aligned RAM accesses with byte-write enables, performs load lane extraction with sign/zero extension, and flags misaligned accesses. Stalls the core for the configurable RAM read latency through a small FSM.

## Interface
- RD_LATENCY, 1, cycles from ram_en (read) to valid ram_rdata; legal range 1..7
- clka  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM stage holds a load or store
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- req_unsigned  in  1  zero-extend load (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  core must hold MEM stage and request inputs
- rdata_valid  out  1  rdata holds completed load data
- rdata  out  32  extended load data
- addr_err  out  1  misaligned access this cycle
- bad_vaddr  out  32  address of last misaligned access
- ram_en  out  1  RAM enable
- ram_we  out  4  byte write enables
- ram_addr  out  32  {req_addr[31:2],2'b00}
- ram_wdata  out  32  lane-replicated store data
- ram_rdata  in  32  RAM read word
- perf_stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- States: IDLE, WAIT, RESP.
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0. In IDLE with req_valid and misaligned: addr_err=1 (combinational), bad_vaddr registered on that edge, ram_en=0, ram_we=0, stall=0, stay IDLE.
- Store (IDLE, aligned): ram_en=1, ram_we = byte: 4'b0001<<addr[1:0]; half: addr[1]?4'b1100:4'b0011; word: 4'b1111. ram_wdata = byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata. No stall, stay IDLE.
- Load (IDLE, aligned): ram_en=1, ram_we=0, stall=1, cnt←1, go WAIT.
- WAIT: stall=1, ram_en=0. If cnt==RD_LATENCY: register extracted rdata, go RESP; else cnt←cnt+1.
- RESP: stall=0, rdata_valid=1 for exactly one cycle; req inputs ignored (same load retiring); go IDLE.
- Extraction: byte lane addr[1:0], half lane addr[1]; sign-extend unless req_unsigned; word passes through.
- req_valid low in WAIT (flush): return to IDLE next edge, no rdata_valid, RAM data discarded.
- ram_addr, ram_we, ram_wdata are zero whenever ram_en=0.

## Timing
- Reset: state IDLE, cnt 0, rdata 0, bad_vaddr 0, perf_stall_cnt 0; all outputs 0. Reset mid-WAIT aborts the read.
- Load: issue cycle T (stall=1), capture at T+RD_LATENCY, rdata_valid at T+RD_LATENCY+1 with stall=0; RD_LATENCY+1 stall cycles per load.
- Store: zero stall; RAM writes on the edge ending cycle T.
- Back-to-back loads: second load issues in the cycle after RESP.
- Core holds all req_* stable while stall=1.

## Configuration
- DMEM_PERF_CNT_EN defined: perf_stall_cnt increments every cycle stall=1, saturating at 32'hFFFF_FFFF, reset 0.
- Undefined: counter not built; perf_stall_cnt tied to 0.

## Structure
- Package mem_if_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, FSM state enum, byte-enable constants.
- One sub-module: dmem_load_ext (combinational lane select and extension), instantiated once.

## Test plan
- RD_LATENCY=1, load addr 0x103, size byte, signed, ram_rdata 0x80AA_BBCC -> stall 2 cycles, rdata_valid with rdata 0xFFFF_FF80.
- RD_LATENCY=3, lhu addr 0x202, ram_rdata 0x9ABC_1234 -> 4 stall cycles, rdata 0x0000_9ABC.
- sh addr 0x102 wdata 0x0000_BEEF -> ram_we 4'b1100, ram_wdata 0xBEEF_BEEF, stall 0.
- lw addr 0x101 -> addr_err=1, ram_en=0, bad_vaddr 0x0000_0101 next cycle, stall 0.
- Load issued, req_valid dropped in WAIT -> IDLE next cycle, no rdata_valid; separate run with rst low mid-WAIT -> all outputs 0 immediately.
- With DMEM_PERF_CNT_EN, RD_LATENCY=2, three back-to-back loads -> perf_stall_cnt=9.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared encodings for the data-memory access unit: request sizes, FSM states,
// byte-enable patterns and the alignment check.
package mem_if_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Reserved size 2'b11 is handled exactly like a word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic result;
    case (size)
      SZ_BYTE: result = 1'b0;
      SZ_HALF: result = lsb[0];
      default: result = (lsb != 2'b00);
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load lane extraction: picks the addressed byte/halfword out of a RAM word and
// sign- or zero-extends it; words pass straight through.
module dmem_load_ext
  import mem_if_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lanes[gi] = word[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = byte_lanes[lane];
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (size)
      SZ_BYTE: data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
      SZ_HALF: data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_if.sv
// MEM-stage data-memory access unit: aligned RAM accesses with byte enables,
// load extraction, misalignment flagging and a read-latency stall FSM.
// Optional stall-cycle counter is built when DMEM_PERF_CNT_EN is defined.
module data_mem_if
  import mem_if_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic [31:0] bad_vaddr,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [31:0] perf_stall_cnt
);

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_e      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [31:0] bad_vaddr_reg, bad_vaddr_next;
  logic [31:0] ext_data;
  logic [3:0]  store_be;
  logic [31:0] store_data;

  dmem_load_ext u_load_ext (
    .word        (ram_rdata),
    .lane        (req_addr[1:0]),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .data        (ext_data)
  );

  always_comb begin
    store_be   = BE_WORD;
    store_data = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        store_be   = BE_BYTE0 << req_addr[1:0];
        store_data = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        store_be   = req_addr[1] ? BE_HALF_HI : BE_HALF_LO;
        store_data = {2{req_wdata[15:0]}};
      end
      default: begin
        store_be   = BE_WORD;
        store_data = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      rdata_reg     <= 32'd0;
      bad_vaddr_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rdata_reg     <= rdata_next;
      bad_vaddr_reg <= bad_vaddr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rdata_next     = rdata_reg;
    bad_vaddr_next = bad_vaddr_reg;
    stall          = 1'b0;
    rdata_valid    = 1'b0;
    addr_err       = 1'b0;
    ram_en         = 1'b0;
    ram_we         = BE_NONE;
    ram_addr       = 32'd0;
    ram_wdata      = 32'd0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (misaligned(req_size, req_addr[1:0])) begin
            addr_err       = 1'b1;
            bad_vaddr_next = req_addr;
          end else begin
            ram_en   = 1'b1;
            ram_addr = {req_addr[31:2], 2'b00};
            if (req_we) begin
              ram_we    = store_be;
              ram_wdata = store_data;
            end else begin
              stall      = 1'b1;
              cnt_next   = 3'd1;
              state_next = WAIT;
            end
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        // A dropped request means the core flushed MEM; the RAM word is discarded.
        if (!req_valid) begin
          cnt_next   = 3'd0;
          state_next = IDLE;
        end else if (cnt_reg == LAT) begin
          rdata_next = ext_data;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      RESP: begin
        rdata_valid = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Keep every combinational output quiet while reset is held.
    if (!rst) begin
      stall     = 1'b0;
      addr_err  = 1'b0;
      ram_en    = 1'b0;
      ram_we    = BE_NONE;
      ram_addr  = 32'd0;
      ram_wdata = 32'd0;
    end
  end

  assign rdata     = rdata_reg;
  assign bad_vaddr = bad_vaddr_reg;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] perf_cnt_reg;

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      perf_cnt_reg <= 32'd0;
    end else if (stall && (perf_cnt_reg != 32'hFFFF_FFFF)) begin
      perf_cnt_reg <= perf_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_cnt_reg;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_data_mem_if.sv
// Directed bench for data_mem_if: three instances at read latencies 1, 2 and 3
// share request fields but each has its own req_valid.
module tb_data_mem_if;

  logic        clka;
  logic        rst;
  logic        v1, v2, v3;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] ram_rdata;

  logic        stall_a, rdata_valid_a, addr_err_a, ram_en_a;
  logic [31:0] rdata_a, bad_vaddr_a, ram_addr_a, ram_wdata_a, perf_a;
  logic [3:0]  ram_we_a;
  logic        stall_b, rdata_valid_b, addr_err_b, ram_en_b;
  logic [31:0] rdata_b, bad_vaddr_b, ram_addr_b, ram_wdata_b, perf_b;
  logic [3:0]  ram_we_b;
  logic        stall_c, rdata_valid_c, addr_err_c, ram_en_c;
  logic [31:0] rdata_c, bad_vaddr_c, ram_addr_c, ram_wdata_c, perf_c;
  logic [3:0]  ram_we_c;

  int n_vec = 0;
  int n_err = 0;

`ifdef DMEM_PERF_CNT_EN
  localparam logic [31:0] PERF_EXP = 32'd9;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  data_mem_if #(.RD_LATENCY(1)) u_lat1 (
    .clka(clka), .rst(rst), .req_valid(v1), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall_a), .rdata_valid(rdata_valid_a), .rdata(rdata_a), .addr_err(addr_err_a),
    .bad_vaddr(bad_vaddr_a), .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a),
    .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata), .perf_stall_cnt(perf_a)
  );

  data_mem_if #(.RD_LATENCY(2)) u_lat2 (
    .clka(clka), .rst(rst), .req_valid(v2), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall_b), .rdata_valid(rdata_valid_b), .rdata(rdata_b), .addr_err(addr_err_b),
    .bad_vaddr(bad_vaddr_b), .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b),
    .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata), .perf_stall_cnt(perf_b)
  );

  data_mem_if #(.RD_LATENCY(3)) u_lat3 (
    .clka(clka), .rst(rst), .req_valid(v3), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall_c), .rdata_valid(rdata_valid_c), .rdata(rdata_c), .addr_err(addr_err_c),
    .bad_vaddr(bad_vaddr_c), .ram_en(ram_en_c), .ram_we(ram_we_c), .ram_addr(ram_addr_c),
    .ram_wdata(ram_wdata_c), .ram_rdata(ram_rdata), .perf_stall_cnt(perf_c)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic cyc();
    @(posedge clka);
    #1;
  endtask

  task automatic set_valid(input int k, input logic v);
    case (k)
      1: v1 = v;
      2: v2 = v;
      default: v3 = v;
    endcase
  endtask

  function automatic logic sel_stall(input int k);
    return (k == 1) ? stall_a : (k == 2) ? stall_b : stall_c;
  endfunction

  function automatic logic sel_valid(input int k);
    return (k == 1) ? rdata_valid_a : (k == 2) ? rdata_valid_b : rdata_valid_c;
  endfunction

  function automatic logic sel_en(input int k);
    return (k == 1) ? ram_en_a : (k == 2) ? ram_en_b : ram_en_c;
  endfunction

  function automatic logic [31:0] sel_rdata(input int k);
    return (k == 1) ? rdata_a : (k == 2) ? rdata_b : rdata_c;
  endfunction

  function automatic logic [31:0] sel_raddr(input int k);
    return (k == 1) ? ram_addr_a : (k == 2) ? ram_addr_b : ram_addr_c;
  endfunction

  // Issues one load and holds it until rdata_valid or a 20-cycle budget runs out.
  task automatic run_load(input int k, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] word,
                          output int stalls, output bit got, output bit en_in_wait,
                          output logic iss_en, output logic [31:0] iss_addr,
                          output logic [31:0] data);
    cyc();
    req_we = 1'b0; req_size = size; req_unsigned = uns; req_addr = addr;
    ram_rdata = word;
    set_valid(k, 1'b1);
    #1;
    iss_en = sel_en(k);
    iss_addr = sel_raddr(k);
    stalls = sel_stall(k) ? 1 : 0;
    got = 1'b0;
    en_in_wait = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      #1;
      if (sel_valid(k)) begin
        got = 1'b1;
        break;
      end
      if (sel_stall(k)) stalls++;
      if (sel_stall(k) && sel_en(k)) en_in_wait = 1'b1;
    end
    set_valid(k, 1'b0);
    data = sel_rdata(k);
    $display("load lat=%0d addr=%h size=%0d uns=%0d ram=%h -> rdata=%h stalls=%0d",
             k, addr, size, uns, word, data, stalls);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; ram_rdata = 32'd0;
    repeat (2) @(posedge clka);
    #2;
    n_vec++; if (stall_a !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0h exp 0", stall_a); end
    n_vec++; if (ram_en_b !== 1'b0) begin n_err++; $display("FAIL rst_ram_en: got %0h exp 0", ram_en_b); end
    n_vec++; if (rdata_c !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got %h exp 0", rdata_c); end
    n_vec++; if (bad_vaddr_a !== 32'd0) begin n_err++; $display("FAIL rst_bad_vaddr: got %h exp 0", bad_vaddr_a); end
    n_vec++; if (perf_b !== 32'd0) begin n_err++; $display("FAIL rst_perf: got %h exp 0", perf_b); end
    n_vec++; if ({rdata_valid_a, addr_err_a, ram_we_c} !== 6'd0) begin n_err++; $display("FAIL rst_misc: got %h exp 0", {rdata_valid_a, addr_err_a, ram_we_c}); end
    $display("reset checked");
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_load_lat1();
    int stalls; bit got, eiw; logic ie; logic [31:0] ia, d;
    run_load(1, 32'h0000_0103, 2'b00, 1'b0, 32'h80AA_BBCC, stalls, got, eiw, ie, ia, d);
    n_vec++; if (ie !== 1'b1) begin n_err++; $display("FAIL lb_issue_en: got %0h exp 1", ie); end
    n_vec++; if (ia !== 32'h0000_0100) begin n_err++; $display("FAIL lb_issue_addr: got %h exp 00000100", ia); end
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL lb_valid_timeout: got %0d exp 1", got); end
    n_vec++; if (stalls != 2) begin n_err++; $display("FAIL lb_stalls: got %0d exp 2", stalls); end
    n_vec++; if (eiw !== 1'b0) begin n_err++; $display("FAIL lb_en_in_wait: got %0d exp 0", eiw); end
    n_vec++; if (d !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_rdata: got %h exp ffffff80", d); end
    n_vec++; if (stall_a !== 1'b0) begin n_err++; $display("FAIL lb_resp_stall: got %0h exp 0", stall_a); end

    run_load(1, 32'h0000_0200, 2'b01, 1'b0, 32'h9ABC_8001, stalls, got, eiw, ie, ia, d);
    n_vec++; if (d !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh_rdata: got %h exp ffff8001", d); end
    run_load(1, 32'h0000_0101, 2'b00, 1'b1, 32'h80AA_BBCC, stalls, got, eiw, ie, ia, d);
    n_vec++; if (d !== 32'h0000_00BB) begin n_err++; $display("FAIL lbu_rdata: got %h exp 000000bb", d); end
    run_load(1, 32'h0000_0208, 2'b11, 1'b0, 32'h8234_5678, stalls, got, eiw, ie, ia, d);
    n_vec++; if (d !== 32'h8234_5678) begin n_err++; $display("FAIL lw_rsvd_rdata: got %h exp 82345678", d); end
  endtask

  task automatic test_load_lat3();
    int stalls; bit got, eiw; logic ie; logic [31:0] ia, d;
    run_load(3, 32'h0000_0202, 2'b01, 1'b1, 32'h9ABC_1234, stalls, got, eiw, ie, ia, d);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL lhu_valid_timeout: got %0d exp 1", got); end
    n_vec++; if (stalls != 4) begin n_err++; $display("FAIL lhu_stalls: got %0d exp 4", stalls); end
    n_vec++; if (ia !== 32'h0000_0200) begin n_err++; $display("FAIL lhu_issue_addr: got %h exp 00000200", ia); end
    n_vec++; if (d !== 32'h0000_9ABC) begin n_err++; $display("FAIL lhu_rdata: got %h exp 00009abc", d); end
  endtask

  task automatic test_store();
    cyc();
    req_we = 1'b1; req_size = 2'b01; req_addr = 32'h0000_0102; req_wdata = 32'h0000_BEEF; v1 = 1'b1;
    #1;
    $display("store sh addr=%h wdata=%h -> we=%b ram_wdata=%h", req_addr, req_wdata, ram_we_a, ram_wdata_a);
    n_vec++; if (ram_we_a !== 4'b1100) begin n_err++; $display("FAIL sh_we: got %b exp 1100", ram_we_a); end
    n_vec++; if (ram_wdata_a !== 32'hBEEF_BEEF) begin n_err++; $display("FAIL sh_wdata: got %h exp beefbeef", ram_wdata_a); end
    n_vec++; if ({stall_a, ram_en_a} !== 2'b01) begin n_err++; $display("FAIL sh_stall_en: got %b exp 01", {stall_a, ram_en_a}); end
    n_vec++; if (ram_addr_a !== 32'h0000_0100) begin n_err++; $display("FAIL sh_addr: got %h exp 00000100", ram_addr_a); end
    cyc();
    req_size = 2'b00; req_addr = 32'h0000_0101; req_wdata = 32'h1234_5678;
    #1;
    $display("store sb addr=%h wdata=%h -> we=%b ram_wdata=%h", req_addr, req_wdata, ram_we_a, ram_wdata_a);
    n_vec++; if (ram_we_a !== 4'b0010) begin n_err++; $display("FAIL sb_we: got %b exp 0010", ram_we_a); end
    n_vec++; if (ram_wdata_a !== 32'h7878_7878) begin n_err++; $display("FAIL sb_wdata: got %h exp 78787878", ram_wdata_a); end
    cyc();
    req_size = 2'b10; req_addr = 32'h0000_0104; req_wdata = 32'hCAFE_F00D;
    #1;
    $display("store sw addr=%h wdata=%h -> we=%b ram_wdata=%h", req_addr, req_wdata, ram_we_a, ram_wdata_a);
    n_vec++; if ({ram_we_a, ram_wdata_a} !== {4'b1111, 32'hCAFE_F00D}) begin n_err++; $display("FAIL sw_we_wdata: got %b %h exp 1111 cafef00d", ram_we_a, ram_wdata_a); end
    n_vec++; if (ram_addr_a !== 32'h0000_0104) begin n_err++; $display("FAIL sw_addr: got %h exp 00000104", ram_addr_a); end
    cyc();
    v1 = 1'b0;
    #1;
    n_vec++; if ({ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a} !== 69'd0) begin n_err++; $display("FAIL idle_ram_zero: got %h exp 0", {ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a}); end
  endtask

  task automatic test_misaligned();
    cyc();
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0101; v1 = 1'b1;
    #1;
    $display("lw misaligned addr=%h -> addr_err=%0d ram_en=%0d", req_addr, addr_err_a, ram_en_a);
    n_vec++; if (addr_err_a !== 1'b1) begin n_err++; $display("FAIL lw_mis_err: got %0h exp 1", addr_err_a); end
    n_vec++; if ({ram_en_a, ram_we_a, stall_a} !== 6'd0) begin n_err++; $display("FAIL lw_mis_quiet: got %h exp 0", {ram_en_a, ram_we_a, stall_a}); end
    n_vec++; if (ram_addr_a !== 32'd0) begin n_err++; $display("FAIL lw_mis_addr: got %h exp 0", ram_addr_a); end
    cyc();
    v1 = 1'b0;
    #1;
    n_vec++; if (bad_vaddr_a !== 32'h0000_0101) begin n_err++; $display("FAIL lw_bad_vaddr: got %h exp 00000101", bad_vaddr_a); end
    n_vec++; if (addr_err_a !== 1'b0) begin n_err++; $display("FAIL lw_err_clear: got %0h exp 0", addr_err_a); end
    cyc();
    req_we = 1'b1; req_size = 2'b01; req_addr = 32'h0000_0203; v1 = 1'b1;
    #1;
    $display("sh misaligned addr=%h -> addr_err=%0d ram_we=%b", req_addr, addr_err_a, ram_we_a);
    n_vec++; if ({addr_err_a, ram_we_a} !== 5'b1_0000) begin n_err++; $display("FAIL sh_mis: got %b exp 10000", {addr_err_a, ram_we_a}); end
    cyc();
    v1 = 1'b0;
    #1;
    n_vec++; if (bad_vaddr_a !== 32'h0000_0203) begin n_err++; $display("FAIL sh_bad_vaddr: got %h exp 00000203", bad_vaddr_a); end
  endtask

  task automatic test_flush();
    int seen;
    cyc();
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0000_0300;
    ram_rdata = 32'h1111_1111; v3 = 1'b1;
    #1;
    n_vec++; if (stall_c !== 1'b1) begin n_err++; $display("FAIL flush_issue_stall: got %0h exp 1", stall_c); end
    cyc();
    v3 = 1'b0;
    #1;
    n_vec++; if (stall_c !== 1'b1) begin n_err++; $display("FAIL flush_wait_stall: got %0h exp 1", stall_c); end
    cyc();
    #1;
    n_vec++; if (stall_c !== 1'b0) begin n_err++; $display("FAIL flush_idle_stall: got %0h exp 0", stall_c); end
    seen = rdata_valid_c ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      if (rdata_valid_c) seen++;
    end
    $display("flush lat=3 addr=%h -> rdata_valid pulses=%0d rdata=%h", req_addr, seen, rdata_c);
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL flush_no_valid: got %0d exp 0", seen); end
    n_vec++; if (rdata_c !== 32'h0000_9ABC) begin n_err++; $display("FAIL flush_rdata_kept: got %h exp 00009abc", rdata_c); end
  endtask

  task automatic test_back_to_back();
    int  nresp, cycles;
    bit  issue_ok, prev_resp;
    cyc();
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0000_0200;
    ram_rdata = 32'h9ABC_1234; v2 = 1'b1;
    #1;
    nresp = 0; cycles = -1; issue_ok = 1'b1; prev_resp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (prev_resp && !(stall_b && ram_en_b)) issue_ok = 1'b0;
      prev_resp = rdata_valid_b;
      if (rdata_valid_b) begin
        nresp++;
        if (nresp == 3) begin
          v2 = 1'b0;
          cycles = i;
          break;
        end
      end
      cyc();
      #1;
    end
    $display("back-to-back lat=2 three lw -> responses=%0d last at cycle %0d rdata=%h", nresp, cycles, rdata_b);
    n_vec++; if (nresp != 3) begin n_err++; $display("FAIL b2b_responses: got %0d exp 3", nresp); end
    n_vec++; if (cycles != 11) begin n_err++; $display("FAIL b2b_cycles: got %0d exp 11", cycles); end
    n_vec++; if (issue_ok !== 1'b1) begin n_err++; $display("FAIL b2b_reissue: got %0d exp 1", issue_ok); end
    n_vec++; if (rdata_b !== 32'h9ABC_1234) begin n_err++; $display("FAIL b2b_rdata: got %h exp 9abc1234", rdata_b); end
    cyc();
    #1;
    $display("perf_stall_cnt lat=2 -> %0d", perf_b);
    n_vec++; if (perf_b !== PERF_EXP) begin n_err++; $display("FAIL perf_cnt: got %0d exp %0d", perf_b, PERF_EXP); end
    n_vec++; if (stall_b !== 1'b0) begin n_err++; $display("FAIL b2b_idle_stall: got %0h exp 0", stall_b); end
  endtask

  task automatic test_reset_mid_wait();
    cyc();
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0300; ram_rdata = 32'h5555_AAAA; v3 = 1'b1;
    cyc();
    #1;
    n_vec++; if (stall_c !== 1'b1) begin n_err++; $display("FAIL rstw_pre_stall: got %0h exp 1", stall_c); end
    rst = 1'b0;
    #1;
    $display("reset mid-WAIT lat=3 -> stall=%0d rdata=%h bad_vaddr_a=%h", stall_c, rdata_c, bad_vaddr_a);
    n_vec++; if ({stall_c, ram_en_c, rdata_valid_c, addr_err_c} !== 4'd0) begin n_err++; $display("FAIL rstw_ctrl: got %b exp 0000", {stall_c, ram_en_c, rdata_valid_c, addr_err_c}); end
    n_vec++; if ({ram_we_c, ram_addr_c, ram_wdata_c} !== 68'd0) begin n_err++; $display("FAIL rstw_ram: got %h exp 0", {ram_we_c, ram_addr_c, ram_wdata_c}); end
    n_vec++; if (rdata_c !== 32'd0) begin n_err++; $display("FAIL rstw_rdata: got %h exp 0", rdata_c); end
    n_vec++; if (bad_vaddr_a !== 32'd0) begin n_err++; $display("FAIL rstw_bad_vaddr: got %h exp 0", bad_vaddr_a); end
    n_vec++; if (perf_b !== 32'd0) begin n_err++; $display("FAIL rstw_perf: got %h exp 0", perf_b); end
    v3 = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    #1;
    n_vec++; if ({stall_c, rdata_valid_c} !== 2'b00) begin n_err++; $display("FAIL rstw_after: got %b exp 00", {stall_c, rdata_valid_c}); end
  endtask

  initial begin
    test_reset();
    test_load_lat1();
    test_load_lat3();
    test_store();
    test_misaligned();
    test_flush();
    test_back_to_back();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
